// File: rtl/data_ctrl.sv
// data_ctrl: serves committed ROB stores and load-buffer loads on a byte-wide
// synchronous memory bus, one byte per cycle, little-endian.
module data_ctrl #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 'h30000
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  rob_rst_in,
   input  logic                  io_buffer_full_in,
   input  logic                  rob_datactrl_en_in,
   input  logic [ADDR_WIDTH-1:0] rob_datactrl_addr_in,
   input  logic [2:0]            rob_datactrl_width_in,
   input  logic [DATA_WIDTH-1:0] rob_datactrl_data_in,
   output logic                  datactrl_rob_en_out,
   input  logic                  lbuffer_datactrl_en_in,
   input  logic [ADDR_WIDTH-1:0] lbuffer_datactrl_addr_in,
   input  logic [2:0]            lbuffer_datactrl_width_in,
   input  logic                  lbuffer_datactrl_signed_in,
   output logic                  datactrl_lbuffer_en_out,
   output logic [DATA_WIDTH-1:0] datactrl_lbuffer_data_out,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_wr,
   output logic [1:0]            dbg_state
);

   // Handshake: a requester holds en (with address/width/data stable) until it
   // sees its one-cycle done pulse; no request is sampled while a pulse is out.

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_STORE = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;
   localparam logic [1:0] S_LWAIT = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]            state;
   logic [2:0]            cnt;
   logic [2:0]            len;
   logic                  sgn;
   logic [DATA_WIDTH-1:0] sdata;
   logic [DATA_WIDTH-1:0] asm_q;

   logic [2:0]            st_len;
   logic [2:0]            ld_len;
   logic                  idle_ok;
   logic                  store_io_stall;
   logic                  store_go;
   logic                  load_go;
   logic [DATA_WIDTH-1:0] load_word;
   logic [DATA_WIDTH-1:0] load_ext;

   function automatic logic [2:0] width_len(input logic [2:0] w);
      case (w)
         3'b100:  width_len = 3'd4;
         3'b010:  width_len = 3'd2;
         default: width_len = 3'd1;
      endcase
   endfunction

   function automatic logic [7:0] byte_sel(input logic [DATA_WIDTH-1:0] d,
                                           input logic [1:0] idx);
      case (idx)
         2'd0:    byte_sel = d[7:0];
         2'd1:    byte_sel = d[15:8];
         2'd2:    byte_sel = d[23:16];
         default: byte_sel = d[31:24];
      endcase
   endfunction

   assign dbg_state = state;

   // Arbitration: the ack cycle is never a sampling cycle, stores win over loads,
   // and a flush only suppresses load acceptance.
   always_comb begin
      st_len         = width_len(rob_datactrl_width_in);
      ld_len         = width_len(lbuffer_datactrl_width_in);
      idle_ok        = (state == S_IDLE) && !datactrl_rob_en_out && !datactrl_lbuffer_en_out;
      store_io_stall = (rob_datactrl_addr_in >= IO_BASE) && io_buffer_full_in;
      store_go       = idle_ok && rob_datactrl_en_in && (rob_datactrl_width_in != 3'b000)
                       && !store_io_stall;
      load_go        = idle_ok && lbuffer_datactrl_en_in && (lbuffer_datactrl_width_in != 3'b000)
                       && !store_go && !rob_rst_in;
   end

   // Final byte of a load arrives in the LWAIT cycle; merge it before extending.
   always_comb begin
      load_word = asm_q;
      case (cnt)
         3'd1:    load_word[7:0]   = mem_din;
         3'd2:    load_word[15:8]  = mem_din;
         3'd3:    load_word[23:16] = mem_din;
         default: load_word[31:24] = mem_din;
      endcase
      case (len)
         3'd1:    load_ext = sgn ? {{(DATA_WIDTH-8){load_word[7]}}, load_word[7:0]}
                                 : {{(DATA_WIDTH-8){1'b0}}, load_word[7:0]};
         3'd2:    load_ext = sgn ? {{(DATA_WIDTH-16){load_word[15]}}, load_word[15:0]}
                                 : {{(DATA_WIDTH-16){1'b0}}, load_word[15:0]};
         default: load_ext = load_word;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state                     <= S_IDLE;
         cnt                       <= 3'd0;
         len                       <= 3'd0;
         sgn                       <= 1'b0;
         sdata                     <= '0;
         asm_q                     <= '0;
         datactrl_rob_en_out       <= 1'b0;
         datactrl_lbuffer_en_out   <= 1'b0;
         datactrl_lbuffer_data_out <= '0;
         mem_dout                  <= 8'h00;
         mem_a                     <= '0;
         mem_wr                    <= 1'b0;
      end else if (rdy_in) begin
         datactrl_rob_en_out     <= 1'b0;
         datactrl_lbuffer_en_out <= 1'b0;
         case (state)
            S_IDLE: begin
               if (store_go) begin
                  state    <= S_STORE;
                  mem_wr   <= 1'b1;
                  mem_a    <= rob_datactrl_addr_in;
                  mem_dout <= rob_datactrl_data_in[7:0];
                  sdata    <= rob_datactrl_data_in;
                  len      <= st_len;
                  cnt      <= 3'd1;
               end else if (load_go) begin
                  state  <= S_LOAD;
                  mem_wr <= 1'b0;
                  mem_a  <= lbuffer_datactrl_addr_in;
                  len    <= ld_len;
                  sgn    <= lbuffer_datactrl_signed_in;
                  cnt    <= 3'd1;
                  asm_q  <= '0;
               end
            end
            // cnt counts bytes already driven; stores ignore flushes.
            S_STORE: begin
               if (cnt < len) begin
                  mem_a    <= mem_a + ADDR_ONE;
                  mem_dout <= byte_sel(sdata, cnt[1:0]);
                  cnt      <= cnt + 3'd1;
               end else begin
                  mem_wr              <= 1'b0;
                  datactrl_rob_en_out <= 1'b1;
                  state               <= S_IDLE;
               end
            end
            // mem_din lags mem_a by one cycle, so byte cnt-2 is on the bus now.
            S_LOAD: begin
               if (rob_rst_in) begin
                  state  <= S_IDLE;
                  mem_wr <= 1'b0;
               end else begin
                  case (cnt)
                     3'd2:    asm_q[7:0]   <= mem_din;
                     3'd3:    asm_q[15:8]  <= mem_din;
                     3'd4:    asm_q[23:16] <= mem_din;
                     default: ;
                  endcase
                  if (cnt < len) begin
                     mem_a <= mem_a + ADDR_ONE;
                     cnt   <= cnt + 3'd1;
                  end else begin
                     state <= S_LWAIT;
                  end
               end
            end
            default: begin
               if (rob_rst_in) begin
                  state  <= S_IDLE;
                  mem_wr <= 1'b0;
               end else begin
                  datactrl_lbuffer_data_out <= load_ext;
                  datactrl_lbuffer_en_out   <= 1'b1;
                  state                     <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_ctrl.sv
// Directed bench for data_ctrl: byte-serial stores/loads, arbitration, flush,
// IO stall, reset and rdy freeze against hand-computed cycle timing.
module tb_data_ctrl;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd2;
   localparam logic [1:0] ST_LWAIT = 2'd3;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic        rob_rst_in = 1'b0;
   logic        io_buffer_full_in = 1'b0;
   logic        rob_datactrl_en_in = 1'b0;
   logic [31:0] rob_datactrl_addr_in = '0;
   logic [2:0]  rob_datactrl_width_in = '0;
   logic [31:0] rob_datactrl_data_in = '0;
   logic        datactrl_rob_en_out;
   logic        lbuffer_datactrl_en_in = 1'b0;
   logic [31:0] lbuffer_datactrl_addr_in = '0;
   logic [2:0]  lbuffer_datactrl_width_in = '0;
   logic        lbuffer_datactrl_signed_in = 1'b0;
   logic        datactrl_lbuffer_en_out;
   logic [31:0] datactrl_lbuffer_data_out;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] ram  [logic [31:0]];
   logic [7:0] wram [logic [31:0]];

   data_ctrl dut (
      .clk_in                     (clk_in),
      .rst_in                     (rst_in),
      .rdy_in                     (rdy_in),
      .rob_rst_in                 (rob_rst_in),
      .io_buffer_full_in          (io_buffer_full_in),
      .rob_datactrl_en_in         (rob_datactrl_en_in),
      .rob_datactrl_addr_in       (rob_datactrl_addr_in),
      .rob_datactrl_width_in      (rob_datactrl_width_in),
      .rob_datactrl_data_in       (rob_datactrl_data_in),
      .datactrl_rob_en_out        (datactrl_rob_en_out),
      .lbuffer_datactrl_en_in     (lbuffer_datactrl_en_in),
      .lbuffer_datactrl_addr_in   (lbuffer_datactrl_addr_in),
      .lbuffer_datactrl_width_in  (lbuffer_datactrl_width_in),
      .lbuffer_datactrl_signed_in (lbuffer_datactrl_signed_in),
      .datactrl_lbuffer_en_out    (datactrl_lbuffer_en_out),
      .datactrl_lbuffer_data_out  (datactrl_lbuffer_data_out),
      .mem_din                    (mem_din),
      .mem_dout                   (mem_dout),
      .mem_a                      (mem_a),
      .mem_wr                     (mem_wr),
      .dbg_state                  (dbg_state)
   );

   // Clock / reset block
   always #5 clk_in = ~clk_in;

   // Synchronous RAM model: read data one cycle after the address; frozen with rdy_in.
   always @(posedge clk_in) begin
      if (rdy_in) begin
         if (mem_wr) wram[mem_a] = mem_dout;
         mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Call in cycle 0 with the store request already driven.
   task automatic run_store(input string tag, input logic [31:0] addr, input int nb,
                            input logic [31:0] data);
      for (int k = 1; k <= nb; k++) begin
         tick();
         check({tag, " wr"},   32'(mem_wr), 32'd1);
         check({tag, " a"},    mem_a, addr + 32'(k - 1));
         check({tag, " dout"}, 32'(mem_dout), (data >> (8 * (k - 1))) & 32'hFF);
         check({tag, " rack"}, 32'(datactrl_rob_en_out), 32'd0);
         check({tag, " lack"}, 32'(datactrl_lbuffer_en_out), 32'd0);
      end
      tick();
      check({tag, " rack_pulse"}, 32'(datactrl_rob_en_out), 32'd1);
      check({tag, " wr_off"},     32'(mem_wr), 32'd0);
      check({tag, " lack_off"},   32'(datactrl_lbuffer_en_out), 32'd0);
      rob_datactrl_en_in    = 1'b0;
      rob_datactrl_width_in = 3'b000;
      tick();
      check({tag, " rack_end"}, 32'(datactrl_rob_en_out), 32'd0);
   endtask

   // Call in cycle 0 with the load request already driven.
   task automatic run_load(input string tag, input logic [31:0] addr, input int nb,
                           input logic [31:0] exp);
      for (int k = 1; k <= nb; k++) begin
         tick();
         check({tag, " a"},    mem_a, addr + 32'(k - 1));
         check({tag, " wr"},   32'(mem_wr), 32'd0);
         check({tag, " lack"}, 32'(datactrl_lbuffer_en_out), 32'd0);
      end
      tick();
      check({tag, " lack_w"}, 32'(datactrl_lbuffer_en_out), 32'd0);
      tick();
      check({tag, " lack_pulse"}, 32'(datactrl_lbuffer_en_out), 32'd1);
      check({tag, " data"},       datactrl_lbuffer_data_out, exp);
      check({tag, " rack_off"},   32'(datactrl_rob_en_out), 32'd0);
      lbuffer_datactrl_en_in    = 1'b0;
      lbuffer_datactrl_width_in = 3'b000;
      tick();
      check({tag, " lack_end"}, 32'(datactrl_lbuffer_en_out), 32'd0);
   endtask

   task automatic drive_store(input logic [31:0] addr, input logic [2:0] w, input logic [31:0] d);
      rob_datactrl_en_in    = 1'b1;
      rob_datactrl_addr_in  = addr;
      rob_datactrl_width_in = w;
      rob_datactrl_data_in  = d;
   endtask

   task automatic drive_load(input logic [31:0] addr, input logic [2:0] w, input logic sg);
      lbuffer_datactrl_en_in     = 1'b1;
      lbuffer_datactrl_addr_in   = addr;
      lbuffer_datactrl_width_in  = w;
      lbuffer_datactrl_signed_in = sg;
   endtask

   initial begin
      ram[32'h20]  = 8'h80;
      ram[32'h41]  = 8'h34;  ram[32'h42]  = 8'h12;
      ram[32'h51]  = 8'h01;  ram[32'h52]  = 8'h80;
      ram[32'h200] = 8'h78;  ram[32'h201] = 8'h56;
      ram[32'h202] = 8'h34;  ram[32'h203] = 8'h12;

      // Reset state
      tick(); tick();
      check("rst wr",    32'(mem_wr), 32'd0);
      check("rst a",     mem_a, 32'd0);
      check("rst dout",  32'(mem_dout), 32'd0);
      check("rst rack",  32'(datactrl_rob_en_out), 32'd0);
      check("rst lack",  32'(datactrl_lbuffer_en_out), 32'd0);
      check("rst ldata", datactrl_lbuffer_data_out, 32'd0);
      check("rst state", 32'(dbg_state), 32'(ST_IDLE));
      rst_in = 1'b0;
      tick();

      // 1: SW
      drive_store(32'h1000, 3'b100, 32'hDEADBEEF);
      run_store("sw", 32'h1000, 4, 32'hDEADBEEF);
      check("sw ram3", 32'(wram.exists(32'h1003) ? wram[32'h1003] : 8'h00), 32'hDE);

      // 2: LB / LBU
      drive_load(32'h20, 3'b001, 1'b1);
      run_load("lb", 32'h20, 1, 32'hFFFFFF80);
      drive_load(32'h20, 3'b001, 1'b0);
      run_load("lbu", 32'h20, 1, 32'h00000080);

      // 3: LHU / LH, unaligned
      drive_load(32'h41, 3'b010, 1'b0);
      run_load("lhu", 32'h41, 2, 32'h00001234);
      drive_load(32'h51, 3'b010, 1'b1);
      run_load("lh", 32'h51, 2, 32'hFFFF8001);

      // 4: store and load together: store first, load accepted at c3, ack c9
      drive_store(32'h100, 3'b001, 32'h000000A5);
      drive_load(32'h200, 3'b100, 1'b0);
      run_store("arb_sb", 32'h100, 1, 32'h000000A5);
      run_load("arb_lw", 32'h200, 4, 32'h12345678);

      // 5: flush aborts in-flight load; store in the next cycle completes
      drive_load(32'h200, 3'b100, 1'b0);
      tick();
      tick();
      check("fl a2", mem_a, 32'h201);
      rob_rst_in = 1'b1;
      tick();
      rob_rst_in = 1'b0;
      check("fl lack",  32'(datactrl_lbuffer_en_out), 32'd0);
      check("fl state", 32'(dbg_state), 32'(ST_IDLE));
      check("fl a",     mem_a, 32'h201);
      lbuffer_datactrl_en_in = 1'b0;
      drive_store(32'h300, 3'b100, 32'h11223344);
      run_store("fl_sw", 32'h300, 4, 32'h11223344);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("fl no_lack", 32'(datactrl_lbuffer_en_out), 32'd0);
      end

      // Flush in IDLE ignores a load request; it is taken once flush drops
      drive_load(32'h20, 3'b001, 1'b1);
      rob_rst_in = 1'b1;
      tick();
      rob_rst_in = 1'b0;
      check("fli state", 32'(dbg_state), 32'(ST_IDLE));
      run_load("fli_lb", 32'h20, 1, 32'hFFFFFF80);

      // Width 000 store never accepted, so the load proceeds
      drive_store(32'h500, 3'b000, 32'h0);
      drive_load(32'h20, 3'b001, 1'b0);
      run_load("w0_lbu", 32'h20, 1, 32'h00000080);
      check("w0 rack", 32'(datactrl_rob_en_out), 32'd0);
      rob_datactrl_en_in = 1'b0;

      // Address wrap
      drive_store(32'hFFFFFFFF, 3'b010, 32'h0000BEEF);
      run_store("wrap_sh", 32'hFFFFFFFF, 2, 32'h0000BEEF);

      // 6: IO stall
      io_buffer_full_in = 1'b1;
      drive_store(32'h30000, 3'b001, 32'h0000005A);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("io stall wr", 32'(mem_wr), 32'd0);
         check("io stall st", 32'(dbg_state), 32'(ST_IDLE));
      end
      io_buffer_full_in = 1'b0;
      run_store("io_sb", 32'h30000, 1, 32'h0000005A);

      // 7a: reset mid-store
      drive_store(32'h400, 3'b100, 32'h0A0B0C0D);
      tick();
      tick();
      check("rs wr_pre", 32'(mem_wr), 32'd1);
      rst_in = 1'b1;
      tick();
      check("rs wr",    32'(mem_wr), 32'd0);
      check("rs a",     mem_a, 32'd0);
      check("rs dout",  32'(mem_dout), 32'd0);
      check("rs ldata", datactrl_lbuffer_data_out, 32'd0);
      check("rs state", 32'(dbg_state), 32'(ST_IDLE));
      rob_datactrl_en_in = 1'b0;
      rst_in = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("rs no_rack", 32'(datactrl_rob_en_out), 32'd0);
         check("rs no_wr",   32'(mem_wr), 32'd0);
      end

      // 7b: rdy_in low for 3 cycles mid-load: ack moves from c6 to c9
      drive_load(32'h200, 3'b100, 1'b0);
      tick();
      check("rdy a0", mem_a, 32'h200);
      tick();
      check("rdy a1", mem_a, 32'h201);
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rdy frz a",     mem_a, 32'h201);
         check("rdy frz lack",  32'(datactrl_lbuffer_en_out), 32'd0);
         check("rdy frz state", 32'(dbg_state), 32'(ST_LOAD));
      end
      rdy_in = 1'b1;
      tick();
      check("rdy a2", mem_a, 32'h202);
      tick();
      check("rdy a3", mem_a, 32'h203);
      tick();
      check("rdy lwait", 32'(dbg_state), 32'(ST_LWAIT));
      check("rdy lack_w", 32'(datactrl_lbuffer_en_out), 32'd0);
      tick();
      check("rdy lack",  32'(datactrl_lbuffer_en_out), 32'd1);
      check("rdy ldata", datactrl_lbuffer_data_out, 32'h12345678);
      lbuffer_datactrl_en_in = 1'b0;
      tick();
      check("rdy lack_end", 32'(datactrl_lbuffer_en_out), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
